// File: rtl/frequency_generator_pkg.sv
// Shared constants and state encoding for the frequency generator and its companion counter.
package frequency_generator_pkg;

  // Window length and width are shared with the counter so the two cannot diverge.
  localparam int unsigned DEFAULT_UPDATE_PERIOD = 1200;
  localparam int unsigned DEFAULT_BITS          = 11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_TENS = 2'd1,
    STATE_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/frequency_generator_if.sv
// Setpoint and waveform bundle between a stimulus controller and the frequency generator.
interface frequency_generator_if;
  logic       load;
  logic [3:0] tens;
  logic [3:0] units;
  logic       signal;
  logic       busy;
  logic       set_err;
  logic       period_start;

  modport master (
    output load, tens, units,
    input  signal, busy, set_err, period_start
  );

  modport slave (
    input  load, tens, units,
    output signal, busy, set_err, period_start
  );
endinterface

// File: rtl/frequency_generator_bcd_to_binary.sv
// Two-digit BCD to binary converter: adds ten once per cycle while the owner sits in its
// conversion state.
module bcd_to_binary (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       busy,
  output logic [6:0] n,
  output logic       done
);

  logic [3:0] tens_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n         <= 7'd0;
      tens_left <= 4'd0;
    end else if (load) begin
      n         <= {3'b000, units};
      tens_left <= tens;
    end else if (busy && (tens_left != 4'd0)) begin
      n         <= n + 7'd10;
      tens_left <= tens_left - 4'd1;
    end
  end

  assign done = busy && (tens_left == 4'd0);

endmodule

// File: rtl/frequency_generator.sv
// Programmable square-wave source: n rising edges on signal per UPDATE_PERIOD-clock window,
// produced by a Bresenham accumulator stepping 2n per clock.
module frequency_generator
  import frequency_generator_pkg::*;
#(
  parameter int unsigned UPDATE_PERIOD = DEFAULT_UPDATE_PERIOD,
  parameter int unsigned BITS          = DEFAULT_BITS
) (
  input logic                  clk,
  input logic                  reset,
  frequency_generator_if.slave bus
);

  localparam logic [BITS:0]   PeriodWide = (BITS+1)'(UPDATE_PERIOD);
  localparam logic [BITS-1:0] PeriodLast = BITS'(UPDATE_PERIOD - 1);

  state_t          state_q, state_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [BITS-1:0] clk_counter_q, clk_counter_d;
  logic            signal_q, signal_d;
  logic            set_err_q, set_err_d;
  logic [BITS:0]   sum;
  logic            load_ok;
  logic            bad_digit;
  logic [6:0]      n;
  logic            conv_done;

  assign bad_digit = (bus.tens > BCD_MAX) || (bus.units > BCD_MAX);

  bcd_to_binary u_bcd_to_binary (
    .clk   (clk),
    .reset (reset),
    .load  (load_ok),
    .tens  (bus.tens),
    .units (bus.units),
    .busy  (state_q == STATE_TENS),
    .n     (n),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= STATE_IDLE;
      acc_q         <= '0;
      clk_counter_q <= '0;
      signal_q      <= 1'b0;
      set_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      clk_counter_q <= clk_counter_d;
      signal_q      <= signal_d;
      set_err_q     <= set_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    clk_counter_d = clk_counter_q;
    signal_d      = signal_q;
    set_err_d     = 1'b0;
    load_ok       = 1'b0;
    sum           = {1'b0, acc_q} + (BITS+1)'({n, 1'b0});

    // A rejected load only flags the error; the generator keeps running.
    if (bus.load && (state_q != STATE_TENS)) begin
      if (bad_digit) set_err_d = 1'b1;
      else           load_ok   = 1'b1;
    end

    if (load_ok) begin
      acc_d    = '0;
      signal_d = 1'b0;
      state_d  = STATE_TENS;
    end else begin
      unique case (state_q)
        STATE_IDLE: signal_d = 1'b0;
        STATE_TENS: begin
          if (conv_done) begin
            clk_counter_d = '0;
            state_d       = STATE_RUN;
          end
        end
        STATE_RUN: begin
          if (sum >= PeriodWide) begin
            acc_d    = BITS'(sum - PeriodWide);
            signal_d = ~signal_q;
          end else begin
            acc_d = BITS'(sum);
          end
          clk_counter_d = (clk_counter_q == PeriodLast) ? '0 : clk_counter_q + 1'b1;
        end
        default: state_d = STATE_IDLE;
      endcase
    end
  end

  assign bus.signal       = signal_q;
  assign bus.busy         = (state_q == STATE_TENS);
  assign bus.set_err      = set_err_q;
  assign bus.period_start = (state_q == STATE_RUN) && (clk_counter_q == '0);

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench: expected edges-per-window are queued at each setpoint load and
// popped as the monitor closes each window.
module tb_frequency_generator;
  import frequency_generator_pkg::*;

  localparam int unsigned PERIOD = DEFAULT_UPDATE_PERIOD;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];

  frequency_generator_if bus ();

  frequency_generator #(
    .UPDATE_PERIOD (PERIOD),
    .BITS          (DEFAULT_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call just after a negedge; returns at posedge+1 of the sampling edge.
  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    bus.load  = 1'b1;
    bus.tens  = t;
    bus.units = u;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
  endtask

  task automatic push_exp(input int edges, input int windows);
    repeat (windows) exp_q.push_back(edges);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int sig_hi = 0, busy_hi = 0, ps_hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.signal)       sig_hi++;
      if (bus.busy)         busy_hi++;
      if (bus.period_start) ps_hi++;
    end
    check_eq({tag, "_signal_high_cycles"}, sig_hi, 0);
    check_eq({tag, "_busy_high_cycles"}, busy_hi, 0);
    check_eq({tag, "_period_start_cycles"}, ps_hi, 0);
  endtask

  task automatic wait_period_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (bus.period_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Counts rising edges of signal between consecutive window-start samples.
  task automatic measure(input int windows, input string tag);
    bit   ok;
    int   cnt;
    int   exp;
    logic prev;
    wait_period_start(ok);
    if (!ok) begin
      check_eq({tag, "_period_start_timeout"}, 0, 1);
      repeat (windows) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    for (int w = 0; w < windows; w++) begin
      check_eq({tag, "_window_start"}, int'(bus.period_start), 1);
      cnt  = 0;
      prev = bus.signal;
      repeat (PERIOD) begin
        @(negedge clk);
        if (bus.signal && !prev) cnt++;
        prev = bus.signal;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check_eq({tag, "_edges_per_window"}, cnt, exp);
    end
  endtask

  task automatic wait_signal_high(input string tag);
    for (int i = 0; i < PERIOD; i++) begin
      if (bus.signal) return;
      @(negedge clk);
    end
    check_eq({tag, "_signal_high_timeout"}, 0, 1);
  endtask

  task automatic measure_phases(input string tag);
    bit ok;
    int lo = 0, hi = 0;
    wait_period_start(ok);
    check_eq({tag, "_phase_window"}, int'(ok), 1);
    while (!bus.signal && lo < 2 * PERIOD) begin
      lo++;
      @(negedge clk);
    end
    while (bus.signal && hi < 2 * PERIOD) begin
      hi++;
      @(negedge clk);
    end
    check_eq({tag, "_low_phase"}, lo, PERIOD / 2);
    check_eq({tag, "_high_phase"}, hi, PERIOD / 2);
  endtask

  initial begin
    int busy_cycles;
    bus.load  = 1'b0;
    bus.tens  = 4'd0;
    bus.units = 4'd0;

    // Reset state and idle behaviour with no load.
    #2;
    check_eq("reset_signal", int'(bus.signal), 0);
    check_eq("reset_busy", int'(bus.busy), 0);
    check_eq("reset_set_err", int'(bus.set_err), 0);
    check_eq("reset_period_start", int'(bus.period_start), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_watch(3000, "idle");

    // 42: busy for tens+1 cycles, then RUN opens with period_start.
    @(negedge clk);
    push_exp(42, 3);
    do_load(4'd4, 4'd2);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cycles++;
    end
    check_eq("busy_cycles_42", busy_cycles, 5);
    check_eq("first_run_period_start", int'(bus.period_start), 1);
    measure(3, "n42");

    // 1 edge with equal phases, then 99, then a flat line.
    push_exp(1, 1);
    do_load(4'd0, 4'd1);
    measure(1, "n1");
    measure_phases("n1");
    @(negedge clk);
    push_exp(99, 2);
    do_load(4'd9, 4'd9);
    measure(2, "n99");
    push_exp(0, 2);
    do_load(4'd0, 4'd0);
    measure(2, "n0");
    check_eq("n0_signal_low", int'(bus.signal), 0);

    // Bad digit while running at 25.
    push_exp(25, 1);
    do_load(4'd2, 4'd5);
    measure(1, "n25");
    repeat (300) @(negedge clk);
    do_load(4'd10, 4'd3);
    @(negedge clk);
    check_eq("bad_digit_set_err", int'(bus.set_err), 1);
    check_eq("bad_digit_busy", int'(bus.busy), 0);
    @(negedge clk);
    check_eq("bad_digit_set_err_cleared", int'(bus.set_err), 0);
    push_exp(25, 2);
    measure(2, "n25_after_err");

    // Reload while high, then a dropped load during conversion.
    wait_signal_high("reload");
    do_load(4'd3, 4'd0);
    check_eq("reload_signal_forced_low", int'(bus.signal), 0);
    check_eq("reload_busy", int'(bus.busy), 1);
    @(negedge clk);
    do_load(4'd9, 4'd9);
    check_eq("tens_load_no_set_err", int'(bus.set_err), 0);
    push_exp(30, 2);
    measure(2, "n30");

    // Asynchronous reset mid-RUN.
    push_exp(57, 1);
    do_load(4'd5, 4'd7);
    measure(1, "n57");
    wait_signal_high("async_reset");
    #2 reset = 1'b0;
    #1;
    check_eq("async_reset_signal", int'(bus.signal), 0);
    check_eq("async_reset_busy", int'(bus.busy), 0);
    check_eq("async_reset_set_err", int'(bus.set_err), 0);
    check_eq("async_reset_period_start", int'(bus.period_start), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_watch(2500, "post_reset");
    @(negedge clk);
    push_exp(3, 1);
    do_load(4'd0, 4'd3);
    measure(1, "n3_after_reset");

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
